// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue sequencer.
package alu_seq_pkg;

    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_AW = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLG_W  = 4;

    // Flag bit positions within {S,V,C,Z}
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_S = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PASS = 2'b10,
        OP_NEG  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller in front of the registered ALU stage.
// Reads operands over one register-file read port, drives the ALU, then
// writes the result back and latches the ALU flags into status.
// Optional feature macro: ALU_SEQ_R0_ZERO_EN (register 0 reads as zero and
// is never written).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [AW-1:0]    rs_a,
    input  logic [AW-1:0]    rs_b,
    input  logic [AW-1:0]    rd,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rf_addr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [DW-1:0]    alu_x,
    output logic [DW-1:0]    alu_y,
    output logic [OP_W-1:0]  alu_funsel,
    input  logic [DW-1:0]    alu_z,
    input  logic [FLG_W-1:0] alu_flags,
    output logic [FLG_W-1:0] status
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [AW-1:0]    rs_a_q, rs_a_d;
    logic [AW-1:0]    rs_b_q, rs_b_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    x_q, x_d;
    logic [DW-1:0]    y_q, y_d;
    logic [FLG_W-1:0] status_q, status_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    rdata_eff;

    // Operand read data, with register 0 optionally forced to zero
`ifdef ALU_SEQ_R0_ZERO_EN
    assign rdata_eff = (addr_q == '0) ? '0 : rf_rdata;
`else
    assign rdata_eff = rf_rdata;
`endif

    // Next-state, instruction/operand capture and registered-output decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_a_d   = rs_a_q;
        rs_b_d   = rs_b_q;
        rd_d     = rd_q;
        x_d      = x_q;
        y_d      = y_q;
        status_d = status_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RDA;
                    op_d    = op;
                    rs_a_d  = rs_a;
                    rs_b_d  = rs_b;
                    rd_d    = rd;
                end
            end
            RDA: begin
                x_d     = rdata_eff;
                state_d = op_q[1] ? EXEC : RDB;
            end
            RDB: begin
                y_d     = rdata_eff;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                status_d = alu_flags;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == WB);
`ifdef ALU_SEQ_R0_ZERO_EN
        we_d   = (state_d == WB) && (rd_d != '0);
`else
        we_d   = (state_d == WB);
`endif
        addr_d = ((state_d == IDLE) || (state_d == RDA)) ? rs_a_d : rs_b_d;
    end

    // State, instruction, operand, status and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rs_a_q   <= '0;
            rs_b_q   <= '0;
            rd_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_a_q   <= rs_a_d;
            rs_b_q   <= rs_b_d;
            rd_q     <= rd_d;
            x_q      <= x_d;
            y_q      <= y_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rf_we      = we_q;
    assign rf_addr    = addr_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = alu_z;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign alu_funsel = op_q;
    assign status     = status_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural register file and
// registered ALU around the DUT, instruction-level reference model.
// Honours ALU_SEQ_R0_ZERO_EN when defined for the build.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [AW-1:0]    rs_a, rs_b, rd;
    logic             busy, done, rf_we;
    logic [AW-1:0]    rf_addr, rf_waddr;
    logic [DW-1:0]    rf_rdata, rf_wdata, alu_x, alu_y, alu_z;
    logic [1:0]       alu_funsel;
    logic [3:0]       alu_flags, status;

    alu_op_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_funsel(alu_funsel),
        .alu_z(alu_z), .alu_flags(alu_flags), .status(status)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {flags{S,V,C,Z}, z}
    function automatic logic [19:0] alu_fn(input logic [1:0] fs, input logic [15:0] x,
                                           input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] z;
        logic [3:0]  f;
        f = 4'h0;
        case (fs)
            2'b00:   s = {1'b0, x} + {1'b0, y};
            2'b01:   s = {1'b0, x} + {1'b0, ~y} + 17'd1;
            2'b10:   s = {1'b0, x};
            default: s = {1'b0, ~x} + 17'd1;
        endcase
        z = s[15:0];
        f[FLG_S] = z[15];
        f[FLG_Z] = (z == 16'h0);
        f[FLG_C] = s[16];
        case (fs)
            2'b00:   f[FLG_V] = (x[15] == y[15]) && (z[15] != x[15]);
            2'b01:   f[FLG_V] = (x[15] != y[15]) && (z[15] != x[15]);
            2'b10:   f[FLG_V] = 1'b0;
            default: f[FLG_V] = (x == 16'h8000);
        endcase
        return {f, z};
    endfunction

    // Environment: register file with a backdoor write port, and counters
    logic [DW-1:0] regs [NREG];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    int unsigned   wr_cnt = 0;
    int unsigned   done_cnt = 0;

    assign rf_rdata = regs[rf_addr];

    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            regs[rf_waddr] <= rf_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (bd_we) begin
            regs[bd_addr] <= bd_data;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Environment: ALU with registered result and flags
    always @(posedge clk) begin
        {alu_flags, alu_z} <= alu_fn(alu_funsel, alu_x, alu_y);
    end

    // Reference model state
    logic [DW-1:0] m_regs [NREG];
    logic [DW-1:0] m_y;
    logic [3:0]    m_status;

    function automatic logic [DW-1:0] m_read(input int r);
`ifdef ALU_SEQ_R0_ZERO_EN
        if (r == 0) return '0;
`endif
        return m_regs[r];
    endfunction

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int r, input logic [DW-1:0] v);
        m_regs[r] = v;
        bd_we   = 1'b1;
        bd_addr = AW'(r);
        bd_data = v;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    // Issue one instruction from an IDLE cycle and check it end to end
    task automatic issue(input logic [1:0] o, input int a, input int b, input int d,
                         input bit hold);
        logic [DW-1:0] xa, yb;
        logic [19:0]   r;
        int            lat_exp, k;
        int unsigned   w0, d0;
        bit            we_exp;
        xa      = m_read(a);
        yb      = o[1] ? m_y : m_read(b);
        r       = alu_fn(o, xa, yb);
        lat_exp = o[1] ? 3 : 4;
        we_exp  = 1'b1;
`ifdef ALU_SEQ_R0_ZERO_EN
        if (d == 0) we_exp = 1'b0;
`endif
        w0 = wr_cnt;
        d0 = done_cnt;
        check("idle_busy", 32'(busy), 32'(0));
        start = 1'b1;
        op    = o;
        rs_a  = AW'(a);
        rs_b  = AW'(b);
        rd    = AW'(d);
        @(posedge clk); #1;
        k = 1;
        if (!hold) start = 1'b0;
        while (done !== 1'b1 && k < 12) begin
            check("run_busy", 32'(busy), 32'(1));
            check("run_we", 32'(rf_we), 32'(0));
            if (hold) begin
                op   = 2'($urandom_range(0, 3));
                rs_a = AW'($urandom_range(0, NREG - 1));
                rs_b = AW'($urandom_range(0, NREG - 1));
                rd   = AW'($urandom_range(0, NREG - 1));
            end
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'(lat_exp));
        check("wb_busy", 32'(busy), 32'(1));
        check("wb_we", 32'(rf_we), 32'(we_exp));
        check("wb_waddr", 32'(rf_waddr), 32'(d));
        check("wb_wdata", 32'(rf_wdata), 32'(r[15:0]));
        check("wb_x", 32'(alu_x), 32'(xa));
        check("wb_y", 32'(alu_y), 32'(yb));
        check("wb_funsel", 32'(alu_funsel), 32'(o));
        check("wb_raddr", 32'(rf_addr), 32'(b));
        check("wb_status_hold", 32'(status), 32'(m_status));
        if (we_exp) m_regs[d] = r[15:0];
        if (!o[1]) m_y = yb;
        m_status = r[19:16];
        @(posedge clk); #1;
        check("post_status", 32'(status), 32'(m_status));
        check("post_busy", 32'(busy), 32'(0));
        check("post_done", 32'(done), 32'(0));
        check("post_we", 32'(rf_we), 32'(0));
        check("post_raddr", 32'(rf_addr), 32'(a));
        check("write_count", 32'(wr_cnt), 32'(w0 + 32'(we_exp)));
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
    endtask

    // Reset asserted while the sequencer is in EXEC
    task automatic reset_in_exec();
        int unsigned w0, d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        op    = OP_ADD;
        rs_a  = AW'(1);
        rs_b  = AW'(2);
        rd    = AW'(6);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("exec_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_status = 4'h0;
        m_y      = '0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_status", 32'(status), 32'(0));
        check("rst_funsel", 32'(alu_funsel), 32'(0));
        check("rst_x", 32'(alu_x), 32'(0));
        repeat (4) begin
            check("rst_we", 32'(rf_we), 32'(0));
            @(posedge clk); #1;
        end
        check("rst_write_count", 32'(wr_cnt), 32'(w0));
        check("rst_done_count", 32'(done_cnt), 32'(d0));
    endtask

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        rs_a  = '0;
        rs_b  = '0;
        rd    = '0;
        m_y      = '0;
        m_status = 4'h0;
        repeat (2) begin @(posedge clk); #1; end
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_we", 32'(rf_we), 32'(0));
        check("reset_status", 32'(status), 32'(0));
        check("reset_funsel", 32'(alu_funsel), 32'(0));
        check("reset_x", 32'(alu_x), 32'(0));
        check("reset_y", 32'(alu_y), 32'(0));
        check("reset_raddr", 32'(rf_addr), 32'(0));

        for (int i = 0; i < int'(NREG); i++) set_reg(i, DW'($urandom));
        set_reg(0, 16'h1234);
        set_reg(1, 16'h7FFF);
        set_reg(2, 16'h0001);
        set_reg(4, 16'h0005);
        rst = 1'b0;
        #0;

        // Add with signed overflow
        issue(OP_ADD, 1, 2, 3, 1'b0);
        check("add_status", 32'(status), 32'(4'b1100));
        // Subtract to zero
        set_reg(1, 16'h0005);
        set_reg(2, 16'h0005);
        issue(OP_SUB, 1, 2, 7, 1'b0);
        check("sub_status", 32'(status), 32'(4'b0011));
        // Negate, RDB skipped, Y retained
        issue(OP_NEG, 4, 4, 5, 1'b0);
        check("neg_result", 32'(m_regs[5]), 32'(16'hFFFB));

        // start held through busy cycles: back-to-back with changing inputs
        issue(OP_ADD, 3, 4, 6, 1'b1);
        issue(OP_PASS, 6, 1, 2, 1'b1);
        issue(OP_SUB, 2, 5, 1, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, NREG - 1)),
                  int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                  (i != 23) && ($urandom_range(0, 3) == 0));
        end

        reset_in_exec();

`ifdef ALU_SEQ_R0_ZERO_EN
        set_reg(0, 16'h1234);
        issue(OP_PASS, 0, 0, 0, 1'b0);
        check("r0_status_z", 32'(status[FLG_Z]), 32'(1));
`endif

        for (int i = 0; i < int'(NREG); i++) begin
            check("regfile", 32'(regs[i]), 32'(m_regs[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
